// File: rtl/sqr_seq_ctrl.sv
// -----------------------------------------------------------------------------
// sqr_seq_ctrl
// State sequencer for the structural square-root datapath. Holds the 4-bit
// control state Q that the downstream decoder turns into register enables,
// tri-state selects, AU ops, SRAM strobes and done. Sequences load, a
// data-dependent iteration loop bounded by MAX_ITER, a fixed finalisation
// tail and a four-phase done/start handshake. No datapath storage.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      level request, sampled in IDLE and DONE
//   abort      synchronous abort, forces IDLE on the next edge (highest priority)
//   loop_cond  datapath comparator flag, 1 = another pass needed (CHECK only)
//   Q          registered state code to the decoder
//   busy       high in every state except IDLE and DONE
//   iter       loop passes completed in the current operation
//   ovf        sticky: loop cut short by MAX_ITER while loop_cond was 1
//   illegal    sticky: an unused state code was entered
// -----------------------------------------------------------------------------
module sqr_seq_ctrl #(
    parameter int MAX_ITER = 8,
    parameter int ITER_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              loop_cond,
    output logic [3:0]        Q,
    output logic              busy,
    output logic [ITER_W-1:0] iter,
    output logic              ovf,
    output logic              illegal
);

    // Codes are fixed by the decoder; do not re-encode.
    typedef enum logic [3:0] {
        IDLE   = 4'b0000,
        INIT   = 4'b0001,
        STEP_A = 4'b0010,
        STEP_B = 4'b0011,
        CHECK  = 4'b1000,
        UPDATE = 4'b1001,
        FIN_A  = 4'b1100,
        FIN_B  = 4'b1101,
        FIN_C  = 4'b1110,
        FIN_D  = 4'b1111,
        OUT    = 4'b0111,
        DONE   = 4'b0101
    } state_t;

    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(MAX_ITER - 1);

    // The state is kept as a plain 4-bit vector so an unused code (SEU or a
    // forced value) is representable and can be detected by the default arm.
    logic [3:0]        r_q;
    logic [ITER_W-1:0] r_iter;
    logic              r_ovf;
    logic              r_illegal;

    logic [3:0]        w_next;
    logic [ITER_W-1:0] w_iter;
    logic              w_ovf;
    logic              w_illegal;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q       <= IDLE;
            r_iter    <= '0;
            r_ovf     <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_q       <= w_next;
            r_iter    <= w_iter;
            r_ovf     <= w_ovf;
            r_illegal <= w_illegal;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a hold value first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        w_next    = r_q;
        w_iter    = r_iter;
        w_ovf     = r_ovf;
        w_illegal = r_illegal;

        if (abort) begin
            // Abort beats every transition and start; stickies are kept.
            w_next = IDLE;
            w_iter = '0;
        end else begin
            case (r_q)
                IDLE: begin
                    if (start) begin
                        w_next    = INIT;
                        w_iter    = '0;
                        w_ovf     = 1'b0;
                        w_illegal = 1'b0;
                    end
                end
                INIT:   w_next = STEP_A;
                STEP_A: w_next = STEP_B;
                STEP_B: w_next = CHECK;
                CHECK: begin
                    if (!loop_cond) begin
                        w_next = FIN_A;
                    end else if (r_iter < LAST_ITER) begin
                        w_next = UPDATE;
                    end else begin
                        // Pass budget exhausted with work still pending.
                        w_next = FIN_A;
                        w_ovf  = 1'b1;
                    end
                end
                UPDATE: begin
                    w_next = STEP_A;
                    // CHECK only enters UPDATE below LAST_ITER; the guard keeps
                    // the counter saturating even from a corrupted state.
                    if (r_iter != LAST_ITER) begin
                        w_iter = r_iter + ITER_W'(1);
                    end
                end
                FIN_A: w_next = FIN_B;
                FIN_B: w_next = FIN_C;
                FIN_C: w_next = FIN_D;
                FIN_D: w_next = OUT;
                OUT:   w_next = DONE;
                DONE: begin
                    // Four-phase handshake: start must drop before IDLE.
                    if (!start) begin
                        w_next = IDLE;
                    end
                end
                default: begin
                    w_next    = IDLE;
                    w_illegal = 1'b1;
                end
            endcase
        end
    end

    assign Q       = r_q;
    assign busy    = (r_q != IDLE) && (r_q != DONE);
    assign iter    = r_iter;
    assign ovf     = r_ovf;
    assign illegal = r_illegal;

endmodule

// File: tb/tb_sqr_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sqr_seq_ctrl
// Self-checking bench for sqr_seq_ctrl: reset state, a table of loop_cond
// patterns with their expected start->DONE latency, pass count and overflow,
// hand-written abort / illegal-state / async-reset sequences, and randomized
// operations compared against a trace model built from the sequencing rules.
// -----------------------------------------------------------------------------
module tb_sqr_seq_ctrl;

    localparam int MAX_ITER = 8;
    localparam int ITER_W   = 4;

    localparam logic [3:0] S_IDLE   = 4'b0000;
    localparam logic [3:0] S_INIT   = 4'b0001;
    localparam logic [3:0] S_STEP_A = 4'b0010;
    localparam logic [3:0] S_STEP_B = 4'b0011;
    localparam logic [3:0] S_CHECK  = 4'b1000;
    localparam logic [3:0] S_UPDATE = 4'b1001;
    localparam logic [3:0] S_FIN_B  = 4'b1101;
    localparam logic [3:0] S_DONE   = 4'b0101;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              start     = 1'b0;
    logic              abort     = 1'b0;
    logic              loop_cond = 1'b0;
    logic [3:0]        Q;
    logic              busy;
    logic [ITER_W-1:0] iter;
    logic              ovf;
    logic              illegal;

    sqr_seq_ctrl #(.MAX_ITER(MAX_ITER), .ITER_W(ITER_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .loop_cond (loop_cond),
        .Q         (Q),
        .busy      (busy),
        .iter      (iter),
        .ovf       (ovf),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs driven 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_q(input logic [3:0] target, input int budget, input string name);
        int c = 0;
        while (Q !== target && c < budget) begin
            step();
            c++;
        end
        check(name, 32'(Q), 32'(target));
    endtask

    // Table entry: loop_cond decision per CHECK visit (LSB = first CHECK).
    typedef struct {
        logic [7:0] pattern;
        int         done_cyc;
        int         exp_iter;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v, input int idx);
        int cyc  = 0;
        int nchk = 0;
        start     = 1'b1;
        loop_cond = 1'b0;
        while (Q !== S_DONE && cyc < 100) begin
            step();
            cyc++;
            if (Q === S_CHECK) begin
                loop_cond = (nchk < 8) ? v.pattern[nchk] : 1'b0;
                nchk++;
            end
        end
        check($sformatf("vec%0d done_cycle", idx), 32'(cyc), 32'(v.done_cyc));
        check($sformatf("vec%0d iter", idx), 32'(iter), 32'(v.exp_iter));
        check($sformatf("vec%0d ovf", idx), 32'(ovf), 32'(v.exp_ovf));
        check($sformatf("vec%0d busy_done", idx), 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("vec%0d hold_done", idx), 32'(Q), 32'(S_DONE));
        end
        start = 1'b0;
        step();
        check($sformatf("vec%0d back_idle", idx), 32'(Q), 32'(S_IDLE));
    endtask

    // Randomized operation. The expected trace is built from the sequencing
    // rules: a 4-state lead-in, a 4-state pass per accepted iteration, then a
    // 6-state tail. lc[n] is the loop_cond value presented before edge n.
    task automatic run_random(input int op);
        logic [3:0] exp_q [0:63];
        int         exp_it[0:63];
        logic       lc    [0:63];
        logic [3:0] tail  [0:5];
        int         n;
        int         it;
        int         last;
        int         hold;
        logic       ovf_e;

        tail[0] = 4'b1100; tail[1] = 4'b1101; tail[2] = 4'b1110;
        tail[3] = 4'b1111; tail[4] = 4'b0111; tail[5] = 4'b0101;
        for (int i = 0; i < 64; i++) lc[i] = ($urandom_range(0, 9) < 7);

        exp_q[1] = S_INIT;   exp_q[2] = S_STEP_A;
        exp_q[3] = S_STEP_B; exp_q[4] = S_CHECK;
        for (int i = 1; i <= 4; i++) exp_it[i] = 0;
        n     = 4;
        it    = 0;
        ovf_e = 1'b0;
        while (1) begin
            if (lc[n+1] && it < MAX_ITER - 1) begin
                exp_q[n+1] = S_UPDATE; exp_it[n+1] = it;
                it++;
                exp_q[n+2] = S_STEP_A; exp_it[n+2] = it;
                exp_q[n+3] = S_STEP_B; exp_it[n+3] = it;
                exp_q[n+4] = S_CHECK;  exp_it[n+4] = it;
                n += 4;
            end else begin
                ovf_e = lc[n+1];
                break;
            end
        end
        for (int i = 0; i < 6; i++) begin
            exp_q[n+1+i]  = tail[i];
            exp_it[n+1+i] = it;
        end
        last = n + 6;

        start     = 1'b1;
        loop_cond = lc[1];
        for (int c = 1; c <= last; c++) begin
            step();
            check($sformatf("rand%0d cyc%0d Q", op, c), 32'(Q), 32'(exp_q[c]));
            check($sformatf("rand%0d cyc%0d iter", op, c), 32'(iter), 32'(exp_it[c]));
            loop_cond = lc[c+1];
        end
        check($sformatf("rand%0d ovf", op), 32'(ovf), 32'(ovf_e));
        check($sformatf("rand%0d busy_done", op), 32'(busy), 32'd0);
        hold = $urandom_range(0, 3);
        for (int i = 0; i < hold; i++) begin
            step();
            check($sformatf("rand%0d hold_done", op), 32'(Q), 32'(S_DONE));
        end
        start = 1'b0;
        step();
        check($sformatf("rand%0d back_idle", op), 32'(Q), 32'(S_IDLE));
    endtask

    initial begin
        vecs[0] = '{pattern: 8'b0000_0000, done_cyc: 10, exp_iter: 0, exp_ovf: 1'b0};
        vecs[1] = '{pattern: 8'b0000_0011, done_cyc: 18, exp_iter: 2, exp_ovf: 1'b0};
        vecs[2] = '{pattern: 8'b0000_0001, done_cyc: 14, exp_iter: 1, exp_ovf: 1'b0};
        vecs[3] = '{pattern: 8'b0011_1111, done_cyc: 34, exp_iter: 6, exp_ovf: 1'b0};
        vecs[4] = '{pattern: 8'b0111_1111, done_cyc: 38, exp_iter: 7, exp_ovf: 1'b0};
        vecs[5] = '{pattern: 8'b1111_1111, done_cyc: 38, exp_iter: 7, exp_ovf: 1'b1};

        // Reset state, then idle with start low.
        #12;
        check("reset Q", 32'(Q), 32'(S_IDLE));
        check("reset busy", 32'(busy), 32'd0);
        check("reset iter", 32'(iter), 32'd0);
        check("reset ovf", 32'(ovf), 32'd0);
        check("reset illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle Q", 32'(Q), 32'(S_IDLE));
            check("idle busy", 32'(busy), 32'd0);
            check("idle stickies", 32'({iter, ovf, illegal}), 32'd0);
        end

        // Table vectors.
        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // ovf stays set in IDLE after an overflowed operation, and the next
        // start clears it together with iter.
        check("ovf sticky in idle", 32'(ovf), 32'd1);
        check("iter held in idle", 32'(iter), 32'd7);
        start = 1'b1;
        step();
        check("restart Q", 32'(Q), 32'(S_INIT));
        check("restart clears ovf", 32'(ovf), 32'd0);
        check("restart clears iter", 32'(iter), 32'd0);
        check("restart busy", 32'(busy), 32'd1);
        abort = 1'b1;
        start = 1'b0;
        step();
        abort = 1'b0;
        check("abort at INIT", 32'(Q), 32'(S_IDLE));

        // Abort in UPDATE with start still high: IDLE, then INIT again.
        start     = 1'b1;
        loop_cond = 1'b1;
        wait_q(S_UPDATE, 20, "reach UPDATE");
        abort = 1'b1;
        step();
        check("abort UPDATE Q", 32'(Q), 32'(S_IDLE));
        check("abort UPDATE iter", 32'(iter), 32'd0);
        abort = 1'b0;
        step();
        check("after abort restart", 32'(Q), 32'(S_INIT));
        start = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;

        // Abort in FIN_B after an overflow keeps ovf.
        start     = 1'b1;
        loop_cond = 1'b1;
        wait_q(S_FIN_B, 60, "reach FIN_B ovf");
        check("ovf before abort", 32'(ovf), 32'd1);
        abort = 1'b1;
        step();
        check("abort FIN_B Q", 32'(Q), 32'(S_IDLE));
        check("abort holds ovf", 32'(ovf), 32'd1);
        check("abort clears iter", 32'(iter), 32'd0);
        abort     = 1'b0;
        start     = 1'b0;
        loop_cond = 1'b0;
        step();

        // Unused code 1010 forced into the state register.
        force dut.r_q = 4'b1010;
        step();
        check("illegal flag set", 32'(illegal), 32'd1);
        release dut.r_q;
        step();
        check("illegal -> IDLE", 32'(Q), 32'(S_IDLE));
        check("illegal held", 32'(illegal), 32'd1);
        step();
        check("illegal still held", 32'(illegal), 32'd1);
        start = 1'b1;
        step();
        check("start clears illegal", 32'(illegal), 32'd0);
        check("start after illegal", 32'(Q), 32'(S_INIT));
        start = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;

        // Randomized operations against the trace model.
        for (int op = 0; op < 20; op++) run_random(op);

        // Async reset mid-FIN_B clears state and stickies before any edge.
        start     = 1'b1;
        loop_cond = 1'b1;
        wait_q(S_FIN_B, 60, "reach FIN_B reset");
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset Q", 32'(Q), 32'(S_IDLE));
        check("async reset iter", 32'(iter), 32'd0);
        check("async reset ovf", 32'(ovf), 32'd0);
        check("async reset busy", 32'(busy), 32'd0);
        start     = 1'b0;
        loop_cond = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post reset idle", 32'(Q), 32'(S_IDLE));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sqr_seq_ctrl.md
Name: sqr_seq_ctrl

Overview:
- State sequencer for the structural square-root datapath.
- Holds the 4-bit control state Q and drives it to the downstream control-output decoder, which turns Q into register enables, tri-state selects, AU ops, SRAM strobes and done.
- Sequences load, a data-dependent iteration loop bounded by a counter, a fixed finalisation tail and a done/acknowledge handshake.
- Pure control: no datapath storage.

Parameters:
- MAX_ITER, 8: maximum loop-body passes per operation (must be ≥1).
- ITER_W, 4: width of the iteration counter (2**ITER_W ≥ MAX_ITER).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level request; sampled in IDLE and DONE.
- abort  input  1  synchronous abort; forces IDLE next edge.
- loop_cond  input  1  datapath comparator flag; 1 = another iteration required. Sampled only in CHECK.
- Q  output  4  current state code, registered, to the decoder.
- busy  output  1  high in every state except IDLE and DONE.
- iter  output  ITER_W  loop passes completed in the current operation.
- ovf  output  1  sticky: loop terminated by MAX_ITER while loop_cond=1.
- illegal  output  1  sticky: an unused state code was entered.

Behaviour:
- Reset (async, rst_n=0): Q=0000 (IDLE), iter=0, ovf=0, illegal=0, busy=0. Release is synchronous to the next clk edge.
- State codes are fixed; the decoder depends on them:
  - IDLE=0000, INIT=0001, STEP_A=0010, STEP_B=0011, CHECK=1000, UPDATE=1001.
  - FIN_A=1100, FIN_B=1101, FIN_C=1110, FIN_D=1111, OUT=0111, DONE=0101.
- Transitions, one per clk:
  - IDLE: start=1 → INIT, clear iter/ovf/illegal. Otherwise stay. Inputs are loaded by the decoder while in IDLE.
  - INIT → STEP_A → STEP_B → CHECK, unconditional.
  - CHECK, loop_cond=1 and iter < MAX_ITER-1: → UPDATE.
  - CHECK, loop_cond=1 and iter = MAX_ITER-1: → FIN_A, set ovf.
  - CHECK, loop_cond=0: → FIN_A.
  - UPDATE → STEP_A, iter increments by 1 on this edge.
  - FIN_A → FIN_B → FIN_C → FIN_D → OUT → DONE, unconditional.
  - DONE: stay while start=1. On start=0 → IDLE (four-phase handshake). A new start needs start low for at least one cycle in DONE.
- Counter:
  - iter saturates at MAX_ITER-1 and never wraps.
  - iter holds its value through FIN_* and DONE so the host can read the pass count. It clears only on IDLE→INIT.
- abort=1 in any state: next Q=IDLE, iter=0. ovf and illegal are held. abort has priority over every other transition and over start.
- Unused codes 0100, 0110, 1010, 1011: next state IDLE, illegal set. These codes are reachable only via SEU or forced state.
- Latency:
  - Minimum start→DONE is 10 cycles: INIT..CHECK 4, FIN_A..DONE 6.
  - Each extra iteration adds 4 cycles: UPDATE, STEP_A, STEP_B, CHECK.
  - Maximum is 10 + 4·(MAX_ITER-1).
- Q is a direct register output with no combinational path from inputs, so decoder outputs are glitch-free after clk-to-Q.
- Reset asserted mid-operation: immediate return to IDLE. Stickies clear.

Test Plan:
- Reset then hold start=0 for 5 cycles → Q=0000, busy=0, iter=0, ovf=0, illegal=0 throughout.
- start=1, loop_cond=0 at CHECK → Q sequence 0001,0010,0011,1000,1100,1101,1110,1111,0111,0101. DONE at cycle 10, iter=0. Hold start=1 3 cycles → Q stays 0101. Drop start → Q=0000 next cycle.
- loop_cond=1 for the first 2 CHECKs, then 0 → two UPDATE passes, iter=2 at DONE, DONE at cycle 18, ovf=0.
- loop_cond stuck at 1, MAX_ITER=8 → 7 UPDATE passes, iter=7, ovf=1 at DONE (cycle 38). Next start clears ovf and iter.
- abort=1 while Q=1001 with start still 1 → Q=0000 next cycle, iter=0. If start is still high, the following cycle enters INIT.
- Force Q=1010 via bench force/release → next Q=0000, illegal=1, held until the next start. rst_n low mid-FIN_B → Q=0000 asynchronously, before any clk edge.
